req_encoder_16x4_neg: RTL and testbench

- Sequential 16-to-4 encoder for 16 asynchronous active-low request lines.
- Synchronizes the lines, turns each falling edge into a sticky pending bit, and presents one request at a time as a 4-bit code with a valid/ack handshake.
- Mirrors the active-low 4x16 decode: it also drives the granted line back as an active-low one-hot vector.
- Sits between external or peripheral request sources and the control unit, which consumes code/valid.

---
 rtl/req_encoder_pkg.sv | 31 +++
 rtl/req_encoder_16x4_neg_sync.sv | 30 +++
 rtl/req_encoder_16x4_neg.sv | 128 ++++++++++++
 tb/tb_req_encoder_16x4_neg.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/req_encoder_pkg.sv
// Shared types and helpers for the active-low request encoder.
// Selection helper is used by both priority builds.
package req_encoder_pkg;

  localparam int NUM_REQ = 16;
  localparam int CODE_W  = 4;

  typedef enum logic {
    IDLE,
    PRESENT
  } state_t;

  // First set bit of elig scanning ptr, ptr+1, ... modulo 16.
  function automatic logic [CODE_W-1:0] rr_first(
    input logic [NUM_REQ-1:0] elig,
    input logic [CODE_W-1:0]  ptr
  );
    logic [CODE_W-1:0] idx;
    logic              found;
    rr_first = '0;
    found    = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = ptr + CODE_W'(k);
      if (!found && elig[idx]) begin
        rr_first = idx;
        found    = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/req_encoder_16x4_neg_sync.sv
// Multi-flop synchronizer for asynchronous active-low buses.
// Resets to all-ones so lines start in the inactive state.
module neg_bus_sync #(
  parameter int W      = 16,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_ff [STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) begin
        r_ff[i] <= '1;
      end
    end else begin
      r_ff[0] <= i_d;
      for (int i = 1; i < STAGES; i++) begin
        r_ff[i] <= r_ff[i-1];
      end
    end
  end

  assign o_q = r_ff[STAGES-1];

endmodule

// File: rtl/req_encoder_16x4_neg.sv
// 16-to-4 encoder for async active-low requests, valid/ack handshake.
// Define REQ_ENCODER_FIXED_PRIO_EN for fixed lowest-index priority.
module req_encoder_16x4_neg #(
  parameter int SYNC_STAGES = 2,
  parameter int NUM_REQ     = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] req_n,
  input  logic [15:0] mask_n,
  output logic [3:0]  code,
  output logic        valid,
  input  logic        ack,
  output logic [15:0] grant_n,
  output logic [15:0] pending
);

  import req_encoder_pkg::*;

  if (NUM_REQ != 16) begin : g_bad_num
    $error("NUM_REQ must be 16");
  end
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("SYNC_STAGES must be 2..4");
  end

  logic [15:0] w_sync;
  logic [15:0] w_fall;
  logic [15:0] w_elig;
  logic [15:0] w_clr;
  logic [15:0] r_prev;
  logic [15:0] r_pending;
  logic [3:0]  r_code;
  logic [3:0]  w_code_nxt;
  state_t      r_state;
  state_t      w_state_nxt;

  neg_bus_sync #(
    .W      (16),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (reset_n),
    .i_d   (req_n),
    .o_q   (w_sync)
  );

  assign w_fall = r_prev & ~w_sync;
  assign w_elig = r_pending & ~mask_n;

`ifdef REQ_ENCODER_FIXED_PRIO_EN
  always_comb begin
    w_state_nxt = r_state;
    w_code_nxt  = r_code;
    w_clr       = '0;
    unique case (r_state)
      IDLE: begin
        if (|w_elig) begin
          w_state_nxt = PRESENT;
          w_code_nxt  = rr_first(w_elig, 4'd0);
        end
      end
      PRESENT: begin
        if (ack) begin
          w_state_nxt = IDLE;
          w_clr       = 16'h1 << r_code;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end
`else
  logic [3:0] r_ptr;
  logic [3:0] w_ptr_nxt;

  always_comb begin
    w_state_nxt = r_state;
    w_code_nxt  = r_code;
    w_ptr_nxt   = r_ptr;
    w_clr       = '0;
    unique case (r_state)
      IDLE: begin
        if (|w_elig) begin
          w_state_nxt = PRESENT;
          w_code_nxt  = rr_first(w_elig, r_ptr);
        end
      end
      PRESENT: begin
        if (ack) begin
          w_state_nxt = IDLE;
          w_clr       = 16'h1 << r_code;
          w_ptr_nxt   = r_code + 4'd1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr <= '0;
    end else begin
      r_ptr <= w_ptr_nxt;
    end
  end
`endif

  // Set beats clear so an edge coinciding with ack is not lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_prev    <= '1;
      r_pending <= '0;
      r_code    <= '0;
      r_state   <= IDLE;
    end else begin
      r_prev    <= w_sync;
      r_pending <= (r_pending & ~w_clr) | w_fall;
      r_code    <= w_code_nxt;
      r_state   <= w_state_nxt;
    end
  end

  assign valid   = (r_state == PRESENT);
  assign code    = r_code;
  assign pending = r_pending;
  assign grant_n = valid ? ~(16'h1 << r_code) : 16'hFFFF;

endmodule

// File: tb/tb_req_encoder_16x4_neg.sv
// Bench for req_encoder_16x4_neg: directed steps plus random traffic,
// every cycle compared against a behavioural reference model.
module tb_req_encoder_16x4_neg;

  localparam int SS = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] req_n;
  logic [15:0] mask_n;
  logic        ack;
  logic [3:0]  code;
  logic        valid;
  logic [15:0] grant_n;
  logic [15:0] pending;

  int n_chk = 0;
  int n_err = 0;

  // reference model state
  logic [15:0] mq[$];
  logic [15:0] m_prev;
  logic [15:0] m_pend;
  int          m_code;
  int          m_ptr;
  bit          m_valid;

  req_encoder_16x4_neg #(
    .SYNC_STAGES (SS),
    .NUM_REQ     (16)
  ) dut (
    .clk     (clk),
    .reset_n (rst_n),
    .req_n   (req_n),
    .mask_n  (mask_n),
    .code    (code),
    .valid   (valid),
    .ack     (ack),
    .grant_n (grant_n),
    .pending (pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [15:0] obs,
                     input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    mq = {};
    for (int i = 0; i < SS; i++) mq.push_back(16'hFFFF);
    m_prev  = 16'hFFFF;
    m_pend  = '0;
    m_code  = 0;
    m_ptr   = 0;
    m_valid = 1'b0;
  endtask

  // One rising edge of the specified behaviour.
  task automatic m_edge();
    logic [15:0] s;
    logic [15:0] fall;
    logic [15:0] elig;
    logic [15:0] clr;
    int          idx;
    if (!rst_n) begin
      m_reset();
      return;
    end
    s    = mq[0];
    fall = m_prev & ~s;
    elig = m_pend & ~mask_n;
    clr  = '0;
    if (m_valid) begin
      if (ack) begin
        clr[m_code] = 1'b1;
        m_ptr       = (m_code + 1) % 16;
        m_valid     = 1'b0;
      end
    end else if (elig != 0) begin
      for (int k = 15; k >= 0; k--) begin
`ifdef REQ_ENCODER_FIXED_PRIO_EN
        idx = k;
`else
        idx = (m_ptr + k) % 16;
`endif
        if (elig[idx]) m_code = idx;
      end
      m_valid = 1'b1;
    end
    m_pend = (m_pend & ~clr) | fall;
    m_prev = s;
    mq.push_back(req_n);
    void'(mq.pop_front());
  endtask

  task automatic cmp_all();
    logic [15:0] g;
    g = m_valid ? ~(16'h1 << m_code) : 16'hFFFF;
    chk("valid", {15'b0, valid}, {15'b0, m_valid});
    chk("code", {12'b0, code}, 16'(m_code));
    chk("grant_n", grant_n, g);
    chk("pending", pending, m_pend);
  endtask

  task automatic tick();
    @(posedge clk);
    m_edge();
    #1;
    cmp_all();
  endtask

  task automatic pulse(input logic [15:0] lines, input int len);
    req_n = req_n & ~lines;
    repeat (len) tick();
    req_n = req_n | lines;
  endtask

  task automatic wait_valid(input int lim);
    int t;
    t = 0;
    while (valid !== 1'b1 && t < lim) begin
      tick();
      t++;
    end
    chk("wait_valid", {15'b0, valid}, 16'h1);
  endtask

  task automatic serve(output logic [3:0] got);
    wait_valid(12);
    got = code;
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    m_reset();
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (2) tick();
  endtask

  initial begin
    logic [3:0]  got;
    logic [3:0]  cap_c;
    logic [15:0] cap_g;

    rst_n  = 1'b0;
    req_n  = 16'hFFFF;
    mask_n = 16'h0000;
    ack    = 1'b0;
    m_reset();
    repeat (3) tick();
    chk("rst_valid", {15'b0, valid}, 16'h0);
    chk("rst_grant", grant_n, 16'hFFFF);
    chk("rst_pend", pending, 16'h0);
    chk("rst_code", {12'b0, code}, 16'h0);
    rst_n = 1'b1;
    repeat (2) tick();

    // single held request: exact latency, one grant only
    req_n[5] = 1'b0;
    repeat (3) tick();
    chk("lat_early", {15'b0, valid}, 16'h0);
    tick();
    chk("lat_valid", {15'b0, valid}, 16'h1);
    chk("lat_code", {12'b0, code}, 16'h5);
    chk("lat_grant", grant_n, 16'hFFDF);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("ack_pend5", {15'b0, pending[5]}, 16'h0);
    repeat (10) tick();
    chk("held_nogrant", {15'b0, valid}, 16'h0);
    req_n[5] = 1'b1;
    repeat (3) tick();

    // round-robin ordering and wrap
    do_reset();
    pulse(16'h8204, 2);
    serve(got); chk("rr0", {12'b0, got}, 16'd2);
    serve(got); chk("rr1", {12'b0, got}, 16'd9);
    serve(got); chk("rr2", {12'b0, got}, 16'd15);
    pulse(16'h8004, 2);
    serve(got); chk("rr3", {12'b0, got}, 16'd2);
    serve(got); chk("rr4", {12'b0, got}, 16'd15);

    // masked line captures pending but is not selected
    do_reset();
    mask_n[3] = 1'b1;
    pulse(16'h0008, 2);
    repeat (6) tick();
    chk("mask_valid", {15'b0, valid}, 16'h0);
    chk("mask_pend3", {15'b0, pending[3]}, 16'h1);
    mask_n[3] = 1'b0;
    repeat (2) tick();
    chk("unmask_valid", {15'b0, valid}, 16'h1);
    chk("unmask_code", {12'b0, code}, 16'h3);
    serve(got);
    repeat (2) tick();

    // new edge on presented line lands in the ack cycle
    do_reset();
    pulse(16'h0080, 2);
    wait_valid(12);
    chk("col_code", {12'b0, code}, 16'h7);
    req_n[7] = 1'b0;
    repeat (SS) tick();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("col_pend7", {15'b0, pending[7]}, 16'h1);
    chk("col_idle", {15'b0, valid}, 16'h0);
    tick();
    chk("col_regrant", {15'b0, valid}, 16'h1);
    chk("col_code2", {12'b0, code}, 16'h7);
    req_n[7] = 1'b1;
    serve(got);
    repeat (4) tick();

    // outputs frozen while presenting
    do_reset();
    pulse(16'h0800, 2);
    wait_valid(12);
    cap_c = code;
    cap_g = grant_n;
    for (int i = 0; i < 10; i++) begin
      mask_n = 16'($urandom);
      req_n  = 16'($urandom);
      tick();
      chk("stab_code", {12'b0, code}, {12'b0, cap_c});
      chk("stab_grant", grant_n, cap_g);
    end
    chk("stab_idx", {12'b0, cap_c}, 16'd11);
    req_n  = 16'hFFFF;
    mask_n = 16'h0000;
    ack = 1'b1;
    tick();
    ack = 1'b0;

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0)
        req_n[$urandom_range(0, 15)] ^= 1'b1;
      if ($urandom_range(0, 15) == 0)
        mask_n = ($urandom_range(0, 1) == 0) ? 16'h0 : 16'($urandom);
      ack = ($urandom_range(0, 2) == 0);
      tick();
    end
    ack    = 1'b0;
    mask_n = 16'h0000;

    // reset in the middle of a handshake
    req_n = 16'hFFFF;
    do_reset();
    pulse(16'h0010, 2);
    wait_valid(12);
    rst_n = 1'b0;
    #1;
    m_reset();
    chk("mid_valid", {15'b0, valid}, 16'h0);
    chk("mid_grant", grant_n, 16'hFFFF);
    chk("mid_pend", pending, 16'h0);
    chk("mid_code", {12'b0, code}, 16'h0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (10) tick();
    chk("post_rst_idle", {15'b0, valid}, 16'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
